ibex_pext_mac_seq: RTL
======================

# ibex_pext_mac_seq

Multi-cycle sequencer for the Zpn 32x32 multiply-accumulate operations (MADDR32, MSUBR32, KMMAC, KMMACu, KMMSB, KMMSBu). It time-shares the single 17x17 signed multiplier in the Pext ALU across four partial-product passes, accumulates them in a 64-bit register, and then performs the final add or subtract against rd. The final step also applies rounding and 32-bit saturation. It sits in the EX stage beside the Pext ALU and stalls the pipeline through `busy_o`, the same way the multdiv unit does.

## Interface
- `RoundEn`, default 1'b1: when 0, KMMACu/KMMSBu execute as KMMAC/KMMSB (no rounding adder).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  EX-stage op valid; level signal, held until `valid_o`.
- `zpn_operator_i`  in  `zpn_op_e`  Zpn operator; held stable while `busy_o`.
- `op_a_i`, `op_b_i`  in  32 each  multiplicands; held stable while `busy_o`.
- `op_c_i`  in  32  accumulator (old rd); held stable while `busy_o`.
- `kill_i`  in  1  flush; aborts the op in flight.
- `mul_a_o`, `mul_b_o`  out  17 each  signed operands to the shared multiplier.
- `mul_res_i`  in  34  signed product; combinational, same cycle.
- `result_o`  out  32  final rd value; meaningful only when `valid_o` is high.
- `valid_o`  out  1  result valid, one cycle.
- `ov_o`  out  1  saturation occurred (to OV/vxsat); qualified by `valid_o`.
- `busy_o`  out  1  a MAC op is accepted and not yet complete.

## Operation
- Operand halves:
  - `aL = {1'b0, a[15:0]}` and `aH = {a[31], a[31:16]}`; b is split the same way.
- States:
  - `IDLE`: a MAC operator with `valid_i` high starts `PP_LL` in the same cycle, using the live operands.
  - Non-MAC operators are ignored.
- Passes:
  - `PP_LL`: aL*bL, shift 0.
  - `PP_LH`: aL*bH, shift 16.
  - `PP_HL`: aH*bL, shift 16.
  - `PP_HH`: aH*bH, shift 32.
  - `ACC`: final add/subtract.
  - Each product is sign-extended to 64 bits, shifted, and added into `sum_q`.
  - `sum_q` is cleared on entry to `PP_LL`.
- Transitions:
  - LL → LH → HL.
  - HL → HH for KMM* ops.
  - HL → ACC for MADDR32/MSUBR32, which need only the low 32 bits.
  - HH → ACC.
  - ACC → IDLE.
- ACC arithmetic, where `sum` includes the current pass's contribution:
  - MADDR32: `op_c + sum[31:0]`, wraps, `ov_o = 0`.
  - MSUBR32: `op_c - sum[31:0]`, wraps, `ov_o = 0`.
  - `hi = sum[63:32]`. For the u variants with `RoundEn` set, `hi = (sum + 2^31)[63:32]`.
  - KMMAC/KMMACu: 33-bit signed `op_c + hi`.
  - KMMSB/KMMSBu: 33-bit signed `op_c - hi`.
  - The 33-bit result is clamped to [0x80000000, 0x7FFFFFFF]; `ov_o = 1` iff clamped.
- `mul_a_o`/`mul_b_o` are 0 in IDLE and in ACC.

## Timing
- Reset values:
  - State is IDLE and `sum_q = 0`.
  - `valid_o`, `busy_o`, `ov_o` = 0; `result_o` = 0; `mul_*_o` = 0.
- Latency, counting the first `valid_i` cycle as cycle 0:
  - MADDR32/MSUBR32: `valid_o` in cycle 3.
  - KMM*: `valid_o` in cycle 4.
- `valid_o` is combinational in ACC and high for exactly one cycle.
- `busy_o` is high from cycle 0 through the cycle before ACC, and low in ACC so the pipeline advances.
- `kill_i` in any non-IDLE state:
  - The FSM returns to IDLE at the next edge.
  - No `valid_o` or `ov_o` is produced.
  - `kill_i` has priority over ACC completion.
- `kill_i` together with a new `valid_i` in IDLE: the op is not started.
- Back-to-back ops: a new op may start in the cycle after ACC.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and any partial result is discarded.

## Structure
- In `ibex_pkg_pext`:
  - `mac_state_e` (IDLE, PP_LL, PP_LH, PP_HL, PP_HH, ACC).
  - Constant `MAC_ROUND = 64'h8000_0000`.
- Single module, no sub-module.
- The multiplier stays in `ibex_alu_pext`; the port mux into it is selected by `busy_o`.

## Test plan
- MADDR32, `op_c=5`, `a=3`, `b=4` → `result_o=17`, `ov_o=0`, `valid_o` in cycle 3; HH pass not visited.
- MSUBR32, `op_c=0`, `a=0xFFFFFFFF`, `b=2` → `result_o=0x00000002`, `ov_o=0`.
- KMMAC, `op_c=0x7FFFFFFF`, `a=b=0x80000000` → `hi=0x40000000`, `result_o=0x7FFFFFFF`, `ov_o=1`, `valid_o` in cycle 4.
- Rounding check, `op_c=0`, `a=0x00010000`, `b=0x00008000`:
  - KMMACu → `result_o=1`.
  - KMMAC → `result_o=0`.
  - KMMACu with `RoundEn=0` → `result_o=0`.
- KMMSB, `op_c=0x80000000`, `a=b=0x7FFFFFFF` → `hi=0x3FFFFFFF`, `result_o=0x80000000`, `ov_o=1`.
- Abort and restart:
  - Pulse `kill_i` in PP_HL of a KMMAC → IDLE next cycle, no `valid_o`.
  - Start MADDR32 (`op_c=1`, `a=b=0xFFFFFFFF`) the following cycle → `result_o=2`.
  - Repeat with `rst_ni` low mid-op → all outputs return to their reset values.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared types for the Pext unit: Zpn operator encoding, MAC sequencer states
// and operator-class helpers.
package ibex_pkg_pext;

    typedef enum logic [3:0] {
        ZPN_NONE,
        ZPN_ADD16,
        ZPN_SMUL16,
        ZPN_MADDR32,
        ZPN_MSUBR32,
        ZPN_KMMAC,
        ZPN_KMMACU,
        ZPN_KMMSB,
        ZPN_KMMSBU
    } zpn_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PP_LL,
        PP_LH,
        PP_HL,
        PP_HH,
        ACC
    } mac_state_e;

    localparam logic [63:0] MAC_ROUND = 64'h8000_0000;

    function automatic logic is_mac_op(input zpn_op_e op);
        return op inside {ZPN_MADDR32, ZPN_MSUBR32, ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU};
    endfunction

    // KMM* ops need the high word of the product, hence the extra HH pass.
    function automatic logic is_kmm_op(input zpn_op_e op);
        return op inside {ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU};
    endfunction

    function automatic logic is_sub_op(input zpn_op_e op);
        return op inside {ZPN_MSUBR32, ZPN_KMMSB, ZPN_KMMSBU};
    endfunction

    function automatic logic is_round_op(input zpn_op_e op);
        return op inside {ZPN_KMMACU, ZPN_KMMSBU};
    endfunction

endpackage

// File: rtl/ibex_pext_mac_seq.sv
// Multi-cycle 32x32 multiply-accumulate sequencer time-sharing the Pext ALU's
// 17x17 signed multiplier over four partial-product passes.
module ibex_pext_mac_seq
    import ibex_pkg_pext::*;
#(
    parameter bit RoundEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  zpn_op_e     zpn_operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    input  logic        kill_i,
    output logic [16:0] mul_a_o,
    output logic [16:0] mul_b_o,
    input  logic [33:0] mul_res_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        ov_o,
    output logic        busy_o
);

    mac_state_e  state_q, state_d, pass;
    logic [63:0] sum_q, sum_d;
    logic        start;
    logic [16:0] a_lo, a_hi, b_lo, b_hi;
    logic [63:0] prod_ext, pp_shifted;
    logic        is_kmm, is_sub, round_carry, clamped;
    logic [31:0] hi, low_res, sat_res;
    logic [32:0] hi_ext, c_ext, acc_wide;

    assign is_kmm = is_kmm_op(zpn_operator_i);
    assign is_sub = is_sub_op(zpn_operator_i);

    // The LL pass runs in the accept cycle itself, on the live operands.
    assign start = (state_q == IDLE) && valid_i && is_mac_op(zpn_operator_i) && !kill_i;

    always_comb begin
        pass = state_q;
        if (state_q == IDLE) begin
            pass = start ? PP_LL : IDLE;
        end
    end

    assign a_lo = {1'b0, op_a_i[15:0]};
    assign a_hi = {op_a_i[31], op_a_i[31:16]};
    assign b_lo = {1'b0, op_b_i[15:0]};
    assign b_hi = {op_b_i[31], op_b_i[31:16]};

    always_comb begin
        mul_a_o = '0;
        mul_b_o = '0;
        case (pass)
            PP_LL:   begin mul_a_o = a_lo; mul_b_o = b_lo; end
            PP_LH:   begin mul_a_o = a_lo; mul_b_o = b_hi; end
            PP_HL:   begin mul_a_o = a_hi; mul_b_o = b_lo; end
            PP_HH:   begin mul_a_o = a_hi; mul_b_o = b_hi; end
            default: begin mul_a_o = '0;   mul_b_o = '0;   end
        endcase
    end

    assign prod_ext = {{30{mul_res_i[33]}}, mul_res_i};

    always_comb begin
        pp_shifted = '0;
        sum_d      = sum_q;
        case (pass)
            PP_LL: begin
                pp_shifted = prod_ext;
                sum_d      = pp_shifted;
            end
            PP_LH, PP_HL: begin
                pp_shifted = prod_ext << 16;
                sum_d      = sum_q + pp_shifted;
            end
            PP_HH: begin
                pp_shifted = prod_ext << 32;
                sum_d      = sum_q + pp_shifted;
            end
            default: begin
                pp_shifted = '0;
                sum_d      = sum_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (pass)
            PP_LL:   state_d = PP_LH;
            PP_LH:   state_d = PP_HL;
            PP_HL:   state_d = is_kmm ? PP_HH : ACC;
            PP_HH:   state_d = ACC;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
        end
    end

    // Adding 2^31 before taking the high word is the same as adding bit 31 as a carry.
    assign round_carry = RoundEn && is_round_op(zpn_operator_i) && sum_q[31];
    assign hi          = sum_q[63:32] + {31'b0, round_carry};
    assign hi_ext      = {hi[31], hi};
    assign c_ext       = {op_c_i[31], op_c_i};
    assign acc_wide    = is_sub ? (c_ext - hi_ext) : (c_ext + hi_ext);
    assign clamped     = acc_wide[32] != acc_wide[31];
    assign sat_res     = clamped ? (acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_wide[31:0];
    assign low_res     = is_sub ? (op_c_i - sum_q[31:0]) : (op_c_i + sum_q[31:0]);

    assign valid_o  = (state_q == ACC) && !kill_i;
    assign result_o = valid_o ? (is_kmm ? sat_res : low_res) : 32'h0;
    assign ov_o     = valid_o && is_kmm && clamped;
    assign busy_o   = start || (state_q inside {PP_LL, PP_LH, PP_HL, PP_HH});

endmodule
